// File: rtl/shell_responder.sv
// Shell command responder: takes a decoded command on the rising edge of enter_flag and
// streams the ASCII reply (fixed strings, LED acknowledgements, or a decimal Fibonacci number).
module shell_responder #(
  parameter int PROG_TYPE_WIDTH = 3,
  parameter int MAX_FIB         = 24,
  parameter logic [PROG_TYPE_WIDTH-1:0] PROG_FIB     = 0,
  parameter logic [PROG_TYPE_WIDTH-1:0] PROG_HELLO   = 1,
  parameter logic [PROG_TYPE_WIDTH-1:0] PROG_LED_ON  = 2,
  parameter logic [PROG_TYPE_WIDTH-1:0] PROG_LED_OFF = 3,
  parameter logic [PROG_TYPE_WIDTH-1:0] PROG_UNKNOWN = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       enter_flag,
  input  logic [PROG_TYPE_WIDTH-1:0] prog_type,
  input  logic [7:0]                 argu,
  output logic [7:0]                 out_ascii,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic [9:0]                 led
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FIB  = 2'd1;
  localparam logic [1:0] S_BCD  = 2'd2;
  localparam logic [1:0] S_SEND = 2'd3;

  localparam logic [2:0] STR_HELLO = 3'd0;
  localparam logic [2:0] STR_UNK   = 3'd1;
  localparam logic [2:0] STR_OK    = 3'd2;
  localparam logic [2:0] STR_BAD   = 3'd3;
  localparam logic [2:0] STR_OVF   = 3'd4;
  localparam logic [2:0] STR_FIB   = 3'd5;

  localparam logic [7:0] MAX_FIB_L = 8'(MAX_FIB);
  localparam logic [7:0] LF        = 8'h0A;

  // Each reply is 0-terminated and zero-padded to a common 13-byte slot.
  localparam logic [103:0] T_HELLO = {"hello world", 8'h0A, 8'h00};
  localparam logic [103:0] T_UNK   = {"unknown cmd", 8'h0A, 8'h00};
  localparam logic [103:0] T_OK    = {"ok", 8'h0A, 8'h00, 72'h0};
  localparam logic [103:0] T_BAD   = {"bad led", 8'h0A, 8'h00, 32'h0};
  localparam logic [103:0] T_OVF   = {"overflow", 8'h0A, 8'h00, 24'h0};

  function automatic logic [7:0] str_char(input logic [2:0] sel, input logic [3:0] idx);
    logic [103:0] t;
    case (sel)
      STR_HELLO: t = T_HELLO;
      STR_UNK:   t = T_UNK;
      STR_OK:    t = T_OK;
      STR_BAD:   t = T_BAD;
      default:   t = T_OVF;
    endcase
    if (idx > 4'd12) str_char = 8'h00;
    else             str_char = t[8*(12 - int'(idx)) +: 8];
  endfunction

  function automatic logic [15:0] pow10(input logic [2:0] p);
    case (p)
      3'd0:    pow10 = 16'd10000;
      3'd1:    pow10 = 16'd1000;
      3'd2:    pow10 = 16'd100;
      3'd3:    pow10 = 16'd10;
      default: pow10 = 16'd1;
    endcase
  endfunction

  logic [1:0]      state_q, state_d;
  logic            en_q, armed_q;
  logic [9:0]      led_q;
  logic [15:0]     a_q, b_q, rem_q;
  logic [7:0]      cnt_q;
  logic [2:0]      place_q;
  logic [4:0][3:0] dig_q;
  logic [2:0]      sel_q;
  logic [3:0]      ptr_q;
  logic [7:0]      ascii_q;
  logic            valid_q;
  logic            start;
  logic [2:0]      first_nz;
  logic [7:0]      cur_char;

  assign start = armed_q && enter_flag && !en_q && (state_q == S_IDLE);

  // Most-significant nonzero digit; falls back to the units place so zero prints as "0".
  always_comb begin
    first_nz = 3'd4;
    for (int i = 4; i >= 0; i--) begin
      if (dig_q[i] != 4'd0) first_nz = 3'(i);
    end
  end

  always_comb begin
    if (sel_q == STR_FIB) cur_char = (ptr_q < 4'd5) ? {4'h3, dig_q[ptr_q[2:0]]} : LF;
    else                  cur_char = str_char(sel_q, ptr_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (prog_type == PROG_FIB && argu <= MAX_FIB_L) state_d = S_FIB;
          else                                            state_d = S_SEND;
        end
      end
      S_FIB:  if (cnt_q == 8'd0) state_d = S_BCD;
      S_BCD:  if (rem_q < pow10(place_q) && place_q == 3'd4) state_d = S_SEND;
      default: if (valid_q && out_ready && ascii_q == LF) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      armed_q <= 1'b0;
      led_q   <= 10'b0;
      valid_q <= 1'b0;
      ascii_q <= 8'h00;
      sel_q   <= STR_HELLO;
      cnt_q   <= 8'd0;
      ptr_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      en_q    <= enter_flag;
      // A level already high out of reset must drop before it can count as an Enter.
      if (!enter_flag) armed_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ptr_q <= 4'd0;
            cnt_q <= argu;
            case (prog_type)
              PROG_HELLO: sel_q <= STR_HELLO;
              PROG_LED_ON: begin
                if (argu <= 8'd9) begin
                  led_q[argu[3:0]] <= 1'b1;
                  sel_q <= STR_OK;
                end else sel_q <= STR_BAD;
              end
              PROG_LED_OFF: begin
                if (argu <= 8'd9) begin
                  led_q[argu[3:0]] <= 1'b0;
                  sel_q <= STR_OK;
                end else sel_q <= STR_BAD;
              end
              PROG_FIB: begin
                if (argu > MAX_FIB_L) sel_q <= STR_OVF;
                else begin
                  sel_q <= STR_FIB;
                  a_q   <= 16'd0;
                  b_q   <= 16'd1;
                end
              end
              default: sel_q <= STR_UNK;
            endcase
          end
        end
        S_FIB: begin
          if (cnt_q == 8'd0) begin
            rem_q   <= a_q;
            place_q <= 3'd0;
            dig_q   <= '0;
          end else begin
            a_q   <= b_q;
            b_q   <= a_q + b_q;
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_BCD: begin
          if (rem_q >= pow10(place_q)) begin
            rem_q          <= rem_q - pow10(place_q);
            dig_q[place_q] <= dig_q[place_q] + 4'd1;
          end else if (place_q == 3'd4) begin
            ptr_q <= {1'b0, first_nz};
          end else begin
            place_q <= place_q + 3'd1;
          end
        end
        default: begin
          if (!valid_q) begin
            ascii_q <= cur_char;
            valid_q <= 1'b1;
            ptr_q   <= ptr_q + 4'd1;
          end else if (out_ready) begin
            if (ascii_q == LF) begin
              valid_q <= 1'b0;
            end else begin
              ascii_q <= cur_char;
              ptr_q   <= ptr_q + 4'd1;
            end
          end
        end
      endcase
    end
  end

  assign out_ascii = ascii_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != S_IDLE);
  assign led       = led_q;

endmodule
